// File: rtl/fp_cmd_sequencer.sv
// fp_cmd_sequencer
// Decodes command frames arriving byte-by-byte from the front-panel SPI slave.
// A frame has a command byte, then optionally an address byte and a data or
// dummy byte. The block holds the LED, blink-mask, scratch and error-count
// registers, and it chooses the response byte for the next SPI byte slot.
//
// Ports:
//   SCLK      - serial clock; all state changes happen on its rising edge
//   NRST      - asynchronous active-high reset
//   SS        - active-low slave select; while high, any frame in progress is dropped
//   RX_BYTE   - received byte, qualified by RX_VALID
//   RX_VALID  - one-cycle byte-complete strobe
//   TX_BYTE   - response byte for the next slot
//   TX_LOAD   - one-cycle pulse marking that TX_BYTE was updated
//   LEDPORT   - register 0
//   BLINKMASK - register 1
//   BUSY      - high while a frame is part-way through
module fp_cmd_sequencer #(
  parameter logic [7:0] CMD_NOP       = 8'h00,
  parameter logic [7:0] CMD_WRITE_REG = 8'h01,
  parameter logic [7:0] CMD_READ_REG  = 8'h02,
  parameter logic [7:0] CMD_CHIP_ID   = 8'h06,
  parameter logic [7:0] CMD_VENDOR_ID = 8'h19,
  parameter logic [7:0] CHIP_ID       = 8'h71,
  parameter logic [7:0] VENDOR_ID     = 8'hAE,
  parameter logic [7:0] ACK           = 8'h01,
  parameter logic [7:0] NAK           = 8'h80
) (
  input  logic       SCLK,
  input  logic       NRST,
  input  logic       SS,
  input  logic [7:0] RX_BYTE,
  input  logic       RX_VALID,
  output logic [7:0] TX_BYTE,
  output logic       TX_LOAD,
  output logic [7:0] LEDPORT,
  output logic [7:0] BLINKMASK,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    S_CMD    = 2'd0,
    S_ADDR   = 2'd1,
    S_WDATA  = 2'd2,
    S_RDUMMY = 2'd3
  } state_t;

  state_t     state_reg;
  logic [7:0] tx_byte_reg;
  logic       tx_load_reg;
  logic [7:0] led_reg;
  logic [7:0] blink_reg;
  logic [7:0] scratch_reg;
  logic [7:0] errcnt_reg;
  logic [1:0] addr_reg;
  logic       is_write_reg;

  logic [7:0] rd_data;
  logic [7:0] errcnt_inc;

  // Read data is selected by the address byte that is arriving now. The
  // registers still hold their values from before this edge.
  always_comb begin
    rd_data = 8'h00;
    case (RX_BYTE[1:0])
      2'd0:    rd_data = led_reg;
      2'd1:    rd_data = blink_reg;
      2'd2:    rd_data = scratch_reg;
      default: rd_data = errcnt_reg;
    endcase
  end

  // The error count saturates at 8'hFF instead of wrapping to zero.
  assign errcnt_inc = (errcnt_reg == 8'hFF) ? 8'hFF : errcnt_reg + 8'd1;

  always_ff @(posedge SCLK or posedge NRST) begin
    if (NRST) begin
      state_reg    <= S_CMD;
      tx_byte_reg  <= 8'h00;
      tx_load_reg  <= 1'b0;
      led_reg      <= 8'h00;
      blink_reg    <= 8'h00;
      scratch_reg  <= 8'h00;
      errcnt_reg   <= 8'h00;
      addr_reg     <= 2'd0;
      is_write_reg <= 1'b0;
    end else begin
      tx_load_reg <= 1'b0;
      if (SS) begin
        // Deselect drops any partial frame without writing or counting an error.
        state_reg   <= S_CMD;
        tx_byte_reg <= 8'h00;
      end else if (RX_VALID) begin
        tx_load_reg <= 1'b1;
        case (state_reg)
          S_CMD: begin
            if (RX_BYTE == CMD_NOP) begin
              tx_byte_reg <= ACK;
            end else if (RX_BYTE == CMD_CHIP_ID) begin
              tx_byte_reg <= CHIP_ID;
            end else if (RX_BYTE == CMD_VENDOR_ID) begin
              tx_byte_reg <= VENDOR_ID;
            end else if (RX_BYTE == CMD_WRITE_REG || RX_BYTE == CMD_READ_REG) begin
              tx_byte_reg  <= ACK;
              is_write_reg <= (RX_BYTE == CMD_WRITE_REG);
              state_reg    <= S_ADDR;
            end else begin
              tx_byte_reg <= NAK;
              errcnt_reg  <= errcnt_inc;
            end
          end
          S_ADDR: begin
            if (RX_BYTE[7:2] != 6'd0) begin
              tx_byte_reg <= NAK;
              errcnt_reg  <= errcnt_inc;
              state_reg   <= S_CMD;
            end else if (is_write_reg) begin
              addr_reg    <= RX_BYTE[1:0];
              tx_byte_reg <= ACK;
              state_reg   <= S_WDATA;
            end else begin
              tx_byte_reg <= rd_data;
              state_reg   <= S_RDUMMY;
            end
          end
          S_WDATA: begin
            case (addr_reg)
              2'd0:    led_reg     <= RX_BYTE;
              2'd1:    blink_reg   <= RX_BYTE;
              2'd2:    scratch_reg <= RX_BYTE;
              default: errcnt_reg  <= 8'h00;  // read-only: any write clears it
            endcase
            tx_byte_reg <= ACK;
            state_reg   <= S_CMD;
          end
          default: begin
            tx_byte_reg <= 8'h00;
            state_reg   <= S_CMD;
          end
        endcase
      end
    end
  end

  assign TX_BYTE   = tx_byte_reg;
  assign TX_LOAD   = tx_load_reg;
  assign LEDPORT   = led_reg;
  assign BLINKMASK = blink_reg;
  assign BUSY      = (state_reg != S_CMD);

endmodule

// File: tb/tb_fp_cmd_sequencer.sv
module tb_fp_cmd_sequencer;

  logic       SCLK;
  logic       NRST;
  logic       SS;
  logic [7:0] RX_BYTE;
  logic       RX_VALID;
  logic [7:0] TX_BYTE;
  logic       TX_LOAD;
  logic [7:0] LEDPORT;
  logic [7:0] BLINKMASK;
  logic       BUSY;

  int vectors;
  int miscompares;
  int tx_idx;
  logic [7:0] exp_q[$];

  fp_cmd_sequencer dut (
    .SCLK(SCLK),
    .NRST(NRST),
    .SS(SS),
    .RX_BYTE(RX_BYTE),
    .RX_VALID(RX_VALID),
    .TX_BYTE(TX_BYTE),
    .TX_LOAD(TX_LOAD),
    .LEDPORT(LEDPORT),
    .BLINKMASK(BLINKMASK),
    .BUSY(BUSY)
  );

  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // One byte per rising edge. The expected response is queued when the byte is driven.
  task automatic send(input logic [7:0] b, input logic [7:0] exp);
    @(negedge SCLK);
    RX_BYTE  = b;
    RX_VALID = 1'b1;
    exp_q.push_back(exp);
    @(posedge SCLK);
    #1;
    RX_VALID = 1'b0;
  endtask

  // Monitor: every TX_LOAD pulse is checked against the oldest queued expectation.
  initial begin
    tx_idx = 0;
    forever begin
      @(negedge SCLK);
      if (TX_LOAD === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL tx_unexpected: got TX_LOAD=1 TX_BYTE=%02h expected no load", TX_BYTE);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (TX_BYTE !== e) begin
            miscompares++;
            $display("FAIL tx[%0d]: got %02h expected %02h", tx_idx, TX_BYTE, e);
          end else begin
            $display("tx[%0d] = %02h ok", tx_idx, TX_BYTE);
          end
        end
        tx_idx++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    NRST     = 1'b1;
    SS       = 1'b0;
    RX_BYTE  = 8'h00;
    RX_VALID = 1'b0;
    repeat (3) @(negedge SCLK);
    check("reset_tx_byte", TX_BYTE, 8'h00);
    check("reset_tx_load", {7'd0, TX_LOAD}, 8'h00);
    check("reset_led", LEDPORT, 8'h00);
    check("reset_blink", BLINKMASK, 8'h00);
    check("reset_busy", {7'd0, BUSY}, 8'h00);
    NRST = 1'b0;
    @(negedge SCLK);

    // ID commands
    send(8'h06, 8'h71); check("busy_chipid", {7'd0, BUSY}, 8'h00);
    send(8'h19, 8'hAE); check("busy_vendor", {7'd0, BUSY}, 8'h00);
    send(8'h00, 8'h01);

    // write LEDPORT = 5A
    send(8'h01, 8'h01); check("busy_w1", {7'd0, BUSY}, 8'h01);
    send(8'h00, 8'h01); check("busy_w2", {7'd0, BUSY}, 8'h01);
    send(8'h5A, 8'h01); check("busy_w3", {7'd0, BUSY}, 8'h00);
    check("led_5a", LEDPORT, 8'h5A);

    // read LEDPORT back
    send(8'h02, 8'h01);
    send(8'h00, 8'h5A);
    send(8'hFF, 8'h00);
    check("led_after_read", LEDPORT, 8'h5A);

    // two errors: illegal command, illegal address
    send(8'h33, 8'h80);
    send(8'h01, 8'h01);
    send(8'h07, 8'h80); check("busy_bad_addr", {7'd0, BUSY}, 8'h00);
    send(8'h02, 8'h01);
    send(8'h03, 8'h02);
    send(8'h00, 8'h00);
    // clear ERRCNT, then read it back
    send(8'h01, 8'h01);
    send(8'h03, 8'h01);
    send(8'h00, 8'h01);
    send(8'h02, 8'h01);
    send(8'h03, 8'h00);
    send(8'h00, 8'h00);

    // saturation
    for (int i = 0; i < 300; i++) send(8'h33, 8'h80);
    send(8'h02, 8'h01);
    send(8'h03, 8'hFF);
    send(8'h00, 8'h00);
    send(8'h01, 8'h01);
    send(8'h03, 8'h01);
    send(8'h55, 8'h01);
    send(8'h02, 8'h01);
    send(8'h03, 8'h00);
    send(8'h00, 8'h00);

    // abort a write to BLINKMASK
    send(8'h01, 8'h01);
    send(8'h01, 8'h01);
    @(negedge SCLK);
    SS = 1'b1;
    @(posedge SCLK); #1;
    check("abort_busy", {7'd0, BUSY}, 8'h00);
    check("abort_tx_byte", TX_BYTE, 8'h00);
    check("abort_tx_load", {7'd0, TX_LOAD}, 8'h00);
    check("abort_blink", BLINKMASK, 8'h00);
    @(negedge SCLK);
    RX_BYTE  = 8'h06;
    RX_VALID = 1'b1;
    @(posedge SCLK); #1;
    RX_VALID = 1'b0;
    check("ss_rx_no_load", {7'd0, TX_LOAD}, 8'h00);
    check("ss_rx_tx_byte", TX_BYTE, 8'h00);
    @(negedge SCLK);
    SS = 1'b0;
    send(8'h01, 8'h01);
    send(8'h01, 8'h01);
    send(8'hC3, 8'h01);
    check("blink_c3", BLINKMASK, 8'hC3);
    check("led_kept", LEDPORT, 8'h5A);
    send(8'h02, 8'h01);
    send(8'h01, 8'hC3);
    send(8'h00, 8'h00);

    // asynchronous reset in S_WDATA of a scratch write
    send(8'h01, 8'h01);
    send(8'h02, 8'h01);
    @(negedge SCLK);
    #2;
    NRST = 1'b1;
    #1;
    check("nrst_led", LEDPORT, 8'h00);
    check("nrst_blink", BLINKMASK, 8'h00);
    check("nrst_tx_byte", TX_BYTE, 8'h00);
    check("nrst_busy", {7'd0, BUSY}, 8'h00);
    @(negedge SCLK);
    NRST = 1'b0;
    send(8'hAA, 8'h80);   // S_CMD again: 0xAA is an illegal command
    send(8'h02, 8'h01);
    send(8'h02, 8'h00);   // SCRATCH was never written
    send(8'h00, 8'h00);
    send(8'h02, 8'h01);
    send(8'h03, 8'h01);   // one error since reset
    send(8'h00, 8'h00);

    repeat (3) @(negedge SCLK);
    check("queue_drained", exp_q.size() == 0 ? 8'h01 : 8'h00, 8'h01);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp_cmd_sequencer.md
Name: fp_cmd_sequencer

Overview:
Command/response sequencer for the front-panel SPI slave. It consumes whole bytes from the SPI shift register and decodes multi-byte frames: a command byte, an optional address byte and an optional data byte. It owns a small register file that drives the LED port, blink mask and scratch register, plus an error counter. It supplies the next response byte to the SPI transmitter.

Parameters:
CMD_NOP, 8'h00, no-operation command code
CMD_WRITE_REG, 8'h01, register write command code; frame is cmd, addr, data
CMD_READ_REG, 8'h02, register read command code; frame is cmd, addr, dummy
CMD_CHIP_ID, 8'h06, read chip ID command code
CMD_VENDOR_ID, 8'h19, read vendor ID command code
CHIP_ID, 8'h71, value returned for CMD_CHIP_ID
VENDOR_ID, 8'hAE, value returned for CMD_VENDOR_ID
ACK, 8'h01, acknowledge response
NAK, 8'h80, error response

Ports:
SCLK  in  1  serial clock; all state changes on posedge
NRST  in  1  reset, asynchronous, active-high
SS  in  1  slave select, active-low, frame gate
RX_BYTE  in  8  received byte from the shift register; valid when RX_VALID=1
RX_VALID  in  1  one-SCLK byte-complete strobe
TX_BYTE  out  8  response byte for the next SPI byte slot
TX_LOAD  out  1  one-cycle pulse when TX_BYTE is updated
LEDPORT  out  8  register 0
BLINKMASK  out  8  register 1
BUSY  out  1  high while a frame is part-way through (state != S_CMD)

Behaviour:
- Reset (NRST=1, asynchronous): state=S_CMD; TX_BYTE=8'h00; TX_LOAD=0; LEDPORT=0; BLINKMASK=0; SCRATCH=0; ERRCNT=0; BUSY=0.
- Register map: addr 0 LEDPORT (RW); 1 BLINKMASK (RW); 2 SCRATCH (RW); 3 ERRCNT (RO, any write clears it to 0). addr >= 4 is illegal.
- Byte event: a posedge with RX_VALID=1 and SS=0. All updates are registered at that edge. TX_BYTE/TX_LOAD are visible after the edge (latency 1 SCLK). TX_LOAD is 0 on every edge without a byte event.
- S_CMD, byte = command:
  - NOP: TX=ACK; stay in S_CMD.
  - CHIP_ID: TX=CHIP_ID; stay in S_CMD.
  - VENDOR_ID: TX=VENDOR_ID; stay in S_CMD.
  - WRITE_REG or READ_REG: TX=ACK; latch the opcode; go to S_ADDR.
  - Any other code: TX=NAK; ERRCNT++; stay in S_CMD.
- S_ADDR, byte = address:
  - addr >= 4: TX=NAK; ERRCNT++; go to S_CMD.
  - WRITE: latch addr[1:0]; TX=ACK; go to S_WDATA.
  - READ: TX=reg[addr], using the value before this edge; go to S_RDUMMY.
- S_WDATA: reg[addr] <= byte (addr 3 clears ERRCNT instead); TX=ACK; go to S_CMD.
- S_RDUMMY: byte value ignored; TX=8'h00; go to S_CMD.
- ERRCNT: 8-bit, saturates at 8'hFF and does not wrap. When a clearing write and a NAK fall on the same edge, the clear wins. This cannot occur in one frame, but the rule is stated for completeness.
- SS=1 at any posedge: state goes to S_CMD and TX_BYTE=8'h00; TX_LOAD=0; registers and ERRCNT are kept. RX_VALID is ignored while SS=1, and SS=1 wins over a simultaneous RX_VALID. An aborted partial frame does not write and does not count as an error.
- Back-to-back RX_VALID on consecutive edges is legal and each one is processed.
- NRST asserted mid-frame: immediate return to the reset values, including all registers.

Test Plan:
- Reset, then frames 0x06 and 0x19 -> TX_BYTE=0x71 with TX_LOAD pulse, then TX_BYTE=0xAE; BUSY stays 0.
- Write frame 0x01,0x00,0x5A -> TX sequence ACK,ACK,ACK; LEDPORT=0x5A after the third byte; BUSY high between bytes 1 and 3.
- Read frame 0x02,0x00,0xFF after LEDPORT=0x5A -> TX sequence ACK,0x5A,0x00; LEDPORT unchanged.
- Illegal cmd 0x33, then write to addr 0x07 -> NAK, then ACK,NAK; ERRCNT=2 when read via 0x02,0x03; write 0x01,0x03,0x00 clears it to 0. Separately, 300 illegal commands -> ERRCNT=0xFF.
- Write 0x01,0x01 then SS=1 -> state S_CMD, BUSY=0, TX_BYTE=0x00, BLINKMASK unchanged. Next frame 0x01,0x01,0xC3 -> BLINKMASK=0xC3. RX_VALID with SS=1 -> no TX_LOAD.
- NRST pulse during S_WDATA of a write of 0xAA to addr 2 -> SCRATCH=0, LEDPORT=0, TX_BYTE=0 immediately, with no SCLK edge needed.
